// File: rtl/exc_controller_if.sv
// Exception controller signal bundle: external requests, decoder/control
// inputs and the Exc/ExcAck handshake with the datapath exception unit.
interface exc_controller_if #(
    parameter int NIRQ = 4,
    parameter int CNTW = 16
);
    logic [NIRQ-1:0] irq;
    logic [NIRQ-1:0] irq_mask;
    logic            invalid_op;
    logic            eret_in;
    logic            ExcAck;
    logic            Exc;
    logic [3:0]      EStatus;
    logic            ERet;
    logic            busy;
    logic            double_fault;
    logic [CNTW-1:0] exc_count;

    // Datapath / decoder side: drives requests and the acknowledge.
    modport master (
        output irq, irq_mask, invalid_op, eret_in, ExcAck,
        input  Exc, EStatus, ERet, busy, double_fault, exc_count
    );

    // Controller side.
    modport slave (
        input  irq, irq_mask, invalid_op, eret_in, ExcAck,
        output Exc, EStatus, ERet, busy, double_fault, exc_count
    );
endinterface

// File: rtl/exc_controller.sv
// Exception/interrupt sequencer for the LEGv8 datapath exception unit.
// Latches irq rising edges as pending, prioritises invalid_op over the
// lowest-index unmasked pending line, raises Exc with a cause code, waits
// for ExcAck, then holds off new exceptions until a legal ERET.
module exc_controller #(
    parameter int NIRQ = 4,
    parameter int CNTW = 16
) (
    input  logic           clk,
    input  logic           reset,
    exc_controller_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RAISE   = 2'b01,
        HANDLER = 2'b10
    } state_t;

    state_t          state_q, state_d;
    logic [NIRQ-1:0] irq_q;
    logic [NIRQ-1:0] pending;
    logic [NIRQ-1:0] irq_edge;
    logic [NIRQ-1:0] eligible;
    logic [NIRQ-1:0] clr_mask;
    logic            exc_q, exc_d;
    logic [3:0]      estatus_q, estatus_d;
    logic            df_q, df_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            win_valid;
    logic            win_found;
    logic [3:0]      win_code;

    // Edge detect; a same-cycle edge is eligible immediately so Exc follows
    // the sampled request by one cycle.
    always_comb begin
        irq_edge = bus.irq & ~irq_q;
        eligible = (pending | irq_edge) & ~bus.irq_mask;
    end

    // Priority selection: invalid_op first, then lowest-index eligible line.
    always_comb begin
        win_found = 1'b0;
        win_code  = 4'b0000;
        for (int unsigned i = 0; i < NIRQ; i++) begin
            if (eligible[i] && !win_found) begin
                win_found = 1'b1;
                win_code  = {2'b10, 2'(i)};
            end
        end
        if (bus.invalid_op) begin
            win_code = 4'b0001;
        end
        win_valid = bus.invalid_op | win_found;
    end

    // Pending bit cleared on the acknowledge of the interrupt it caused.
    always_comb begin
        clr_mask = '0;
        for (int unsigned i = 0; i < NIRQ; i++) begin
            clr_mask[i] = (state_q == RAISE) && bus.ExcAck && estatus_q[3] &&
                          (estatus_q[1:0] == 2'(i));
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        exc_d     = exc_q;
        estatus_d = estatus_q;
        df_d      = df_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    estatus_d = win_code;
                    exc_d     = 1'b1;
                    state_d   = RAISE;
                end
            end
            RAISE: begin
                if (bus.ExcAck) begin
                    exc_d   = 1'b0;
                    state_d = HANDLER;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNTW'(1);
                    end
                end
            end
            HANDLER: begin
                if (bus.invalid_op) begin
                    df_d = 1'b1;
                end
                if (bus.eret_in) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                exc_d   = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Edge history and pending latch; a new edge wins over a clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q   <= '0;
            pending <= '0;
        end else begin
            irq_q   <= bus.irq;
            pending <= (pending & ~clr_mask) | irq_edge;
        end
    end

    // Registered outputs: Exc, cause, sticky double fault, serviced count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exc_q     <= 1'b0;
            estatus_q <= 4'b0000;
            df_q      <= 1'b0;
            cnt_q     <= '0;
        end else begin
            exc_q     <= exc_d;
            estatus_q <= estatus_d;
            df_q      <= df_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.Exc          = exc_q;
    assign bus.EStatus      = estatus_q;
    assign bus.ERet         = bus.eret_in && (state_q == HANDLER);
    assign bus.busy         = (state_q != IDLE);
    assign bus.double_fault = df_q;
    assign bus.exc_count    = cnt_q;
endmodule

// File: tb/tb_exc_controller.sv
// Directed bench for exc_controller: expected cause codes are queued when a
// request is driven and checked when Exc rises.
module tb_exc_controller;
    localparam int NIRQ = 4;
    localparam int CNTW = 4;

    logic clk;
    logic reset;
    int   vectors;
    int   errors;
    logic [3:0] sb[$];

    exc_controller_if #(.NIRQ(NIRQ), .CNTW(CNTW)) bus ();

    exc_controller #(.NIRQ(NIRQ), .CNTW(CNTW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for Exc, then pop the expected cause and compare.
    task automatic wait_exc(input string tag);
        int n;
        logic [3:0] exp;
        n = 0;
        while (bus.Exc !== 1'b1 && n < 10) begin
            cycle();
            n++;
        end
        chk({tag, " exc"}, 32'(bus.Exc), 32'd1);
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL %s: scoreboard empty, observed %0h expected entry", tag, bus.EStatus);
        end else begin
            exp = sb.pop_front();
            chk({tag, " estatus"}, 32'(bus.EStatus), 32'(exp));
        end
    endtask

    task automatic ack_and_return();
        bus.ExcAck = 1'b1;
        cycle();
        bus.ExcAck = 1'b0;
        bus.eret_in = 1'b1;
        cycle();
        bus.eret_in = 1'b0;
    endtask

    initial begin
        int seen;
        vectors = 0;
        errors  = 0;
        reset          = 1'b1;
        bus.irq        = '0;
        bus.irq_mask   = '0;
        bus.invalid_op = 1'b0;
        bus.eret_in    = 1'b0;
        bus.ExcAck     = 1'b0;
        cycle();
        cycle();
        chk("rst exc", 32'(bus.Exc), 32'd0);
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst estatus", 32'(bus.EStatus), 32'd0);
        chk("rst count", 32'(bus.exc_count), 32'd0);
        chk("rst df", 32'(bus.double_fault), 32'd0);
        reset = 1'b0;
        cycle();

        // T2: irq[2] edge, latency 1, handshake, ERET.
        bus.irq = 4'b0100;
        sb.push_back(4'b1010);
        cycle();
        chk("t2 latency", 32'(bus.Exc), 32'd1);
        wait_exc("t2");
        bus.ExcAck = 1'b1;
        cycle();
        bus.ExcAck = 1'b0;
        chk("t2 ack exc", 32'(bus.Exc), 32'd0);
        chk("t2 ack busy", 32'(bus.busy), 32'd1);
        chk("t2 ack count", 32'(bus.exc_count), 32'd1);
        chk("t2 estatus held", 32'(bus.EStatus), 32'hA);
        bus.eret_in = 1'b1;
        #1;
        chk("t2 eret", 32'(bus.ERet), 32'd1);
        cycle();
        bus.eret_in = 1'b0;
        chk("t2 idle", 32'(bus.busy), 32'd0);
        chk("t2 estatus kept", 32'(bus.EStatus), 32'hA);
        bus.irq = '0;
        cycle();

        // T3: invalid_op beats irq[0]; irq[0] re-raises after one IDLE cycle.
        bus.irq = 4'b0001;
        bus.invalid_op = 1'b1;
        sb.push_back(4'b0001);
        sb.push_back(4'b1000);
        cycle();
        bus.invalid_op = 1'b0;
        wait_exc("t3a");
        ack_and_return();
        chk("t3 idle gap exc", 32'(bus.Exc), 32'd0);
        chk("t3 idle gap busy", 32'(bus.busy), 32'd0);
        cycle();
        chk("t3 reraise", 32'(bus.Exc), 32'd1);
        wait_exc("t3b");
        ack_and_return();
        chk("t3 count", 32'(bus.exc_count), 32'd3);
        bus.irq = '0;
        cycle();

        // T4: masked line stays pending, raises once unmasked.
        bus.irq_mask = 4'b0010;
        bus.irq = 4'b0010;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (bus.Exc !== 1'b0) seen++;
        end
        chk("t4 masked", 32'(seen), 32'd0);
        sb.push_back(4'b1001);
        bus.irq_mask = '0;
        cycle();
        chk("t4 unmask latency", 32'(bus.Exc), 32'd1);
        wait_exc("t4");
        ack_and_return();
        bus.irq = '0;
        cycle();

        // T5: invalid_op in HANDLER sets double_fault; ERET/ExcAck in IDLE ignored.
        bus.irq = 4'b1000;
        sb.push_back(4'b1011);
        cycle();
        bus.irq = '0;
        wait_exc("t5");
        bus.ExcAck = 1'b1;
        cycle();
        bus.ExcAck = 1'b0;
        bus.invalid_op = 1'b1;
        cycle();
        bus.invalid_op = 1'b0;
        chk("t5 df", 32'(bus.double_fault), 32'd1);
        chk("t5 exc", 32'(bus.Exc), 32'd0);
        chk("t5 still handler", 32'(bus.busy), 32'd1);
        bus.eret_in = 1'b1;
        cycle();
        chk("t5 back idle", 32'(bus.busy), 32'd0);
        #1;
        chk("t5 eret idle", 32'(bus.ERet), 32'd0);
        cycle();
        bus.eret_in = 1'b0;
        chk("t5 eret ignored", 32'(bus.busy), 32'd0);
        bus.ExcAck = 1'b1;
        cycle();
        bus.ExcAck = 1'b0;
        chk("t5 ack ignored", 32'(bus.exc_count), 32'd5);
        chk("t5 df sticky", 32'(bus.double_fault), 32'd1);

        // Two simultaneous edges: lowest index first, the other re-raises.
        bus.irq = 4'b0110;
        sb.push_back(4'b1001);
        sb.push_back(4'b1010);
        cycle();
        bus.irq = '0;
        wait_exc("pri a");
        ack_and_return();
        cycle();
        wait_exc("pri b");
        ack_and_return();
        chk("pri count", 32'(bus.exc_count), 32'd7);

        // T1: async reset while in RAISE.
        bus.irq = 4'b0001;
        cycle();
        chk("t1 pre exc", 32'(bus.Exc), 32'd1);
        reset = 1'b1;
        bus.irq = '0;
        #1;
        chk("t1 exc", 32'(bus.Exc), 32'd0);
        chk("t1 busy", 32'(bus.busy), 32'd0);
        chk("t1 count", 32'(bus.exc_count), 32'd0);
        chk("t1 df", 32'(bus.double_fault), 32'd0);
        cycle();
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (bus.Exc !== 1'b0) seen++;
        end
        chk("t1 pending lost", 32'(seen), 32'd0);

        // T6: 17 handshakes saturate a 4-bit counter.
        for (int k = 0; k < 17; k++) begin
            bus.irq = 4'(1 << (k % 4));
            sb.push_back({2'b10, 2'(k % 4)});
            cycle();
            bus.irq = '0;
            wait_exc("t6");
            ack_and_return();
            chk("t6 count", 32'(bus.exc_count), (k + 1 > 15) ? 32'd15 : 32'(k + 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end
endmodule
